// File: rtl/note_pkg.sv
// Shared definitions for the score sequencer and the keyboard note path.
package note_pkg;

  typedef enum logic [1:0] {
    IDLE,
    FETCH,
    WAIT,
    HOLD
  } state_e;

  localparam int unsigned NOTES_PER_OCT = 7;
  localparam logic [3:0]  CODE_REST     = 4'd0;

endpackage

// File: rtl/note_seq_player_if.sv
// Control, ROM and tone-stage signals of the score sequencer.
interface note_seq_player_if #(
  parameter int unsigned NOTE_W = 5,
  parameter int unsigned OCT_W  = 2,
  parameter int unsigned DUR_W  = 4,
  parameter int unsigned ADDR_W = 6
);

  logic                    TICK;
  logic                    START;
  logic                    STOP;
  logic                    LOOP_EN;
  logic [ADDR_W-1:0]       ADDR;
  logic [DUR_W+NOTE_W-1:0] DATA;
  logic [3:0]              CODE;
  logic [OCT_W-1:0]        OCT;
  logic                    REST;
  logic                    BUSY;
  logic                    DONE;

  modport master (
    output TICK, START, STOP, LOOP_EN, DATA,
    input  ADDR, CODE, OCT, REST, BUSY, DONE
  );

  modport slave (
    input  TICK, START, STOP, LOOP_EN, DATA,
    output ADDR, CODE, OCT, REST, BUSY, DONE
  );

endinterface

// File: rtl/note_index_decode.sv
// Note index -> scale code / octave / rest; index 0 and out-of-range indices are rests.
module note_index_decode
  import note_pkg::*;
#(
  parameter int unsigned NOTE_W = 5,
  parameter int unsigned OCT_N  = 3,
  parameter int unsigned OCT_W  = 2
) (
  input  logic [NOTE_W-1:0] inx_i,
  output logic [3:0]        code_o,
  output logic [OCT_W-1:0]  oct_o,
  output logic              rest_o
);

  int unsigned idx;

  always_comb begin
    idx    = 32'(inx_i) - 32'd1;
    code_o = CODE_REST;
    oct_o  = '0;
    rest_o = 1'b1;
    if (inx_i != '0 && 32'(inx_i) <= NOTES_PER_OCT * OCT_N) begin
      code_o = 4'(idx % NOTES_PER_OCT + 32'd1);
      oct_o  = OCT_W'(idx / NOTES_PER_OCT);
      rest_o = 1'b0;
    end
  end

endmodule

// File: rtl/note_seq_player.sv
// Score sequencer: fetches {DUR,INX} words from a 1-cycle ROM and holds each note for DUR ticks.
module note_seq_player
  import note_pkg::*;
#(
  parameter int unsigned NOTE_W = 5,
  parameter int unsigned OCT_N  = 3,
  parameter int unsigned OCT_W  = 2,
  parameter int unsigned DUR_W  = 4,
  parameter int unsigned ADDR_W = 6
) (
  input logic              CLK,
  input logic              RST_N,
  note_seq_player_if.slave bus
);

  localparam logic [ADDR_W-1:0] ADDR_LAST = '1;

  state_e             state_q;
  logic [ADDR_W-1:0]  addr_q;
  logic [ADDR_W-1:0]  addr_d;
  logic [DUR_W-1:0]   cnt_q;
  logic [3:0]         code_q;
  logic [OCT_W-1:0]   oct_q;
  logic               rest_q;
  logic               busy_q;
  logic               done_q;

  logic [DUR_W-1:0]   dur;
  logic [NOTE_W-1:0]  inx;
  logic [3:0]         dec_code;
  logic [OCT_W-1:0]   dec_oct;
  logic               dec_rest;
  logic               last_tick;
  logic               end_of_score;

  assign {dur, inx} = bus.DATA;
  assign addr_d     = addr_q + ADDR_W'(1);

  note_index_decode #(
    .NOTE_W (NOTE_W),
    .OCT_N  (OCT_N),
    .OCT_W  (OCT_W)
  ) u_decode (
    .inx_i  (inx),
    .code_o (dec_code),
    .oct_o  (dec_oct),
    .rest_o (dec_rest)
  );

  // End of score is either a zero-duration marker or expiry of the last ROM entry.
  assign last_tick    = (state_q == HOLD) && bus.TICK && (cnt_q == DUR_W'(1));
  assign end_of_score = ((state_q == WAIT) && (dur == '0)) ||
                        (last_tick && (addr_q == ADDR_LAST));

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q <= IDLE;
      addr_q  <= '0;
      cnt_q   <= '0;
      code_q  <= CODE_REST;
      oct_q   <= '0;
      rest_q  <= 1'b1;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      if (bus.STOP) begin
        state_q <= IDLE;
        addr_q  <= '0;
        code_q  <= CODE_REST;
        oct_q   <= '0;
        rest_q  <= 1'b1;
        busy_q  <= 1'b0;
      end else if (end_of_score) begin
        addr_q <= '0;
        if (bus.LOOP_EN) begin
          state_q <= FETCH;
        end else begin
          state_q <= IDLE;
          code_q  <= CODE_REST;
          oct_q   <= '0;
          rest_q  <= 1'b1;
          busy_q  <= 1'b0;
          done_q  <= 1'b1;
        end
      end else begin
        unique case (state_q)
          IDLE: begin
            if (bus.START) begin
              state_q <= FETCH;
              addr_q  <= '0;
              busy_q  <= 1'b1;
            end
          end
          FETCH: state_q <= WAIT;
          WAIT: begin
            cnt_q   <= dur;
            code_q  <= dec_code;
            oct_q   <= dec_oct;
            rest_q  <= dec_rest;
            state_q <= HOLD;
          end
          HOLD: begin
            if (last_tick) begin
              addr_q  <= addr_d;
              state_q <= FETCH;
            end else if (bus.TICK) begin
              cnt_q <= cnt_q - DUR_W'(1);
            end
          end
          default: state_q <= IDLE;
        endcase
      end
    end
  end

  assign bus.ADDR = addr_q;
  assign bus.CODE = code_q;
  assign bus.OCT  = oct_q;
  assign bus.REST = rest_q;
  assign bus.BUSY = busy_q;
  assign bus.DONE = done_q;

endmodule

// File: tb/tb_note_seq_player.sv
// Bench for note_seq_player: playback-level reference model plus directed score scenarios.
module tb_note_seq_player;

  localparam int unsigned NOTE_W = 5;
  localparam int unsigned OCT_N  = 3;
  localparam int unsigned OCT_W  = 2;
  localparam int unsigned DUR_W  = 4;
  localparam int unsigned ADDR_W = 6;
  localparam int unsigned DEPTH  = 1 << ADDR_W;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  note_seq_player_if #(.NOTE_W(NOTE_W), .OCT_W(OCT_W), .DUR_W(DUR_W), .ADDR_W(ADDR_W)) bus ();

  note_seq_player #(
    .NOTE_W (NOTE_W), .OCT_N (OCT_N), .OCT_W (OCT_W), .DUR_W (DUR_W), .ADDR_W (ADDR_W)
  ) dut (
    .CLK   (clk),
    .RST_N (rst_n),
    .bus   (bus)
  );

  logic [NOTE_W-1:0] d_inx;
  logic [3:0]        d_code;
  logic [OCT_W-1:0]  d_oct;
  logic              d_rest;

  note_index_decode #(.NOTE_W(NOTE_W), .OCT_N(OCT_N), .OCT_W(OCT_W)) u_dec_tb (
    .inx_i  (d_inx),
    .code_o (d_code),
    .oct_o  (d_oct),
    .rest_o (d_rest)
  );

  logic [DUR_W+NOTE_W-1:0] rom [DEPTH];
  always @(posedge clk) bus.DATA <= rom[bus.ADDR];

  int unsigned vectors    = 0;
  int unsigned miscompares = 0;
  int unsigned cyc        = 0;
  int unsigned tick_per   = 8;
  bit          tick_on    = 1'b0;
  bit          chk_on     = 1'b0;

  // Playback model: position in score, fetch latency left, ticks left on the note.
  bit          m_active;
  int unsigned m_lat;
  int unsigned m_rem;
  int unsigned m_addr;
  int unsigned m_code;
  int unsigned m_oct;
  bit          m_rest;
  bit          m_done;

  function automatic void decode_ref(input int unsigned inx, output int unsigned c,
                                     output int unsigned o, output bit r);
    if (inx == 0 || inx > 7 * OCT_N) begin
      c = 0; o = 0; r = 1'b1;
    end else begin
      c = (inx - 1) % 7 + 1; o = (inx - 1) / 7; r = 1'b0;
    end
  endfunction

  function void model_reset();
    m_active = 1'b0; m_lat = 0; m_rem = 0; m_addr = 0;
    m_code = 0; m_oct = 0; m_rest = 1'b1; m_done = 1'b0;
  endfunction

  function void score_end();
    m_addr = 0;
    if (bus.LOOP_EN) begin
      m_lat = 2;
    end else begin
      m_active = 1'b0; m_code = 0; m_oct = 0; m_rest = 1'b1; m_done = 1'b1;
    end
  endfunction

  function void model_step();
    int unsigned word;
    m_done = 1'b0;
    if (bus.STOP) begin
      m_active = 1'b0; m_addr = 0; m_code = 0; m_oct = 0; m_rest = 1'b1;
    end else if (!m_active) begin
      if (bus.START) begin m_active = 1'b1; m_addr = 0; m_lat = 2; end
    end else if (m_lat == 2) begin
      m_lat = 1;
    end else if (m_lat == 1) begin
      word = 32'(rom[m_addr]);
      if ((word >> NOTE_W) == 0) score_end();
      else begin
        m_rem = word >> NOTE_W;
        decode_ref(word % 32, m_code, m_oct, m_rest);
        m_lat = 0;
      end
    end else if (bus.TICK) begin
      m_rem = m_rem - 1;
      if (m_rem == 0) begin
        if (m_addr == DEPTH - 1) score_end();
        else begin m_addr = m_addr + 1; m_lat = 2; end
      end
    end
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) model_reset();
    else        model_step();
  end

  always @(negedge clk) begin
    if (chk_on) begin
      vectors++;
      if (bus.ADDR !== ADDR_W'(m_addr) || bus.CODE !== 4'(m_code) || bus.OCT !== OCT_W'(m_oct) ||
          bus.REST !== m_rest || bus.BUSY !== m_active || bus.DONE !== m_done) begin
        miscompares++;
        $display("FAIL cycle_cmp t=%0t got addr=%0d code=%0d oct=%0d rest=%0b busy=%0b done=%0b want addr=%0d code=%0d oct=%0d rest=%0b busy=%0b done=%0b",
                 $time, bus.ADDR, bus.CODE, bus.OCT, bus.REST, bus.BUSY, bus.DONE,
                 m_addr, m_code, m_oct, m_rest, m_active, m_done);
      end
    end
  end

  task automatic check(input string name, input int unsigned act, input int unsigned exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0d, want %0d", name, act, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
    cyc++;
    bus.TICK = tick_on && (cyc % tick_per == 0);
  endtask

  task automatic steps(input int unsigned n);
    for (int unsigned i = 0; i < n; i++) step();
  endtask

  task automatic go_idle();
    bus.START = 1'b0;
    bus.STOP  = 1'b1;
    step();
    bus.STOP  = 1'b0;
    step();
  endtask

  // Start playback on the cycle right after a tick so tick counts per note are exact.
  task automatic start_aligned();
    for (int unsigned i = 0; i < 16 && !bus.TICK; i++) step();
    step();
    bus.START = 1'b1;
    step();
    bus.START = 1'b0;
  endtask

  task automatic load_score_a();
    for (int unsigned a = 0; a < DEPTH; a++) rom[a] = 9'($urandom);
    rom[0] = {4'd2, 5'd1};
    rom[1] = {4'd3, 5'd8};
    rom[2] = {4'd1, 5'd0};
    rom[3] = {4'd0, 5'($urandom)};
  endtask

  int unsigned n10, n11, nrest, ndone, maxaddr;
  bit          got;
  int unsigned c_ref, o_ref;
  bit          r_ref;

  initial begin
    model_reset();
    bus.TICK = 1'b0; bus.START = 1'b0; bus.STOP = 1'b0; bus.LOOP_EN = 1'b0;
    for (int unsigned a = 0; a < DEPTH; a++) rom[a] = '0;

    for (int unsigned i = 0; i < 32; i++) begin
      d_inx = NOTE_W'(i);
      #1;
      decode_ref(i, c_ref, o_ref, r_ref);
      check($sformatf("decode_%0d", i), {d_code, 2'(d_oct), d_rest}, {4'(c_ref), 2'(o_ref), r_ref});
    end
    d_inx = 5'd8;  #1; check("decode_8_code", d_code, 1);  check("decode_8_oct", d_oct, 1);
    d_inx = 5'd21; #1; check("decode_21_code", d_code, 7); check("decode_21_oct", d_oct, 2);
    d_inx = 5'd22; #1; check("decode_22_rest", d_rest, 1);
    d_inx = 5'd0;  #1; check("decode_0_rest", {d_code, d_rest}, 1);

    chk_on = 1'b1;
    steps(2);
    check("reset_addr", bus.ADDR, 0); check("reset_rest", bus.REST, 1);
    check("reset_busy", bus.BUSY, 0); check("reset_done", bus.DONE, 0);
    rst_n = 1'b1;
    step();

    // Basic score, no loop
    load_score_a(); tick_on = 1'b1; tick_per = 8; bus.LOOP_EN = 1'b0;
    go_idle(); start_aligned();
    n10 = 0; n11 = 0; nrest = 0; got = 1'b0;
    for (int unsigned i = 0; i < 200 && !got; i++) begin
      step();
      if (bus.TICK && bus.BUSY) begin
        if (!bus.REST && bus.CODE == 1 && bus.OCT == 0) n10++;
        if (!bus.REST && bus.CODE == 1 && bus.OCT == 1) n11++;
        if (bus.REST) nrest++;
      end
      if (bus.DONE) got = 1'b1;
    end
    check("s2_done_seen", got, 1);
    check("s2_ticks_note_1_0", n10, 2);
    check("s2_ticks_note_1_1", n11, 3);
    check("s2_ticks_rest", nrest, 1);
    check("s2_busy_at_done", bus.BUSY, 0);
    check("s2_addr_at_done", bus.ADDR, 0);
    step();
    check("s2_done_one_cycle", bus.DONE, 0);

    // Same score, looping
    go_idle(); bus.LOOP_EN = 1'b1; start_aligned();
    n10 = 0; ndone = 0;
    for (int unsigned i = 0; i < 130; i++) begin
      step();
      if (bus.TICK && bus.BUSY && !bus.REST && bus.CODE == 1 && bus.OCT == 0) n10++;
      if (bus.DONE) ndone++;
    end
    check("s3_no_done", ndone, 0);
    check("s3_replay", (n10 >= 3) ? 1 : 0, 1);

    // STOP with simultaneous TICK and START during the second note
    go_idle(); bus.LOOP_EN = 1'b0; start_aligned();
    got = 1'b0;
    for (int unsigned i = 0; i < 100 && !got; i++) begin
      step();
      if (m_active && m_addr == 1 && m_lat == 0) got = 1'b1;
    end
    check("s4_reached_note2", got, 1);
    bus.TICK = 1'b1; bus.STOP = 1'b1; bus.START = 1'b1;
    step();
    bus.STOP = 1'b0; bus.START = 1'b0;
    check("s4_rest", bus.REST, 1); check("s4_addr", bus.ADDR, 0);
    check("s4_done", bus.DONE, 0); check("s4_busy", bus.BUSY, 0);
    check("s4_code", bus.CODE, 0);
    steps(3);
    check("s4_stays_idle", bus.BUSY, 0);

    // Full 64-entry score, DUR=1 each, no end marker
    go_idle();
    for (int unsigned a = 0; a < DEPTH; a++) rom[a] = {4'd1, 5'($urandom_range(1, 21))};
    tick_per = 4; start_aligned();
    got = 1'b0; maxaddr = 0;
    for (int unsigned i = 0; i < 1200 && !got; i++) begin
      step();
      if (bus.BUSY && 32'(bus.ADDR) > maxaddr) maxaddr = 32'(bus.ADDR);
      if (bus.DONE) got = 1'b1;
    end
    check("s5_done_seen", got, 1);
    check("s5_max_addr", maxaddr, 63);
    check("s5_addr_after", bus.ADDR, 0);

    // START while busy ignored, then asynchronous reset mid-note
    go_idle();
    rom[0] = {4'd9, 5'd3}; rom[1] = {4'd2, 5'd10};
    tick_per = 5; start_aligned();
    steps(4);
    check("s6_hold_addr", bus.ADDR, 0); check("s6_hold_code", bus.CODE, 3);
    bus.START = 1'b1; step(); bus.START = 1'b0; step();
    check("s6_start_ignored_addr", bus.ADDR, 0);
    check("s6_start_ignored_busy", bus.BUSY, 1);
    @(posedge clk); #2;
    rst_n = 1'b0;
    #1;
    check("s6_rst_addr", bus.ADDR, 0); check("s6_rst_code", bus.CODE, 0);
    check("s6_rst_oct", bus.OCT, 0);   check("s6_rst_rest", bus.REST, 1);
    check("s6_rst_busy", bus.BUSY, 0); check("s6_rst_done", bus.DONE, 0);
    steps(2);
    rst_n = 1'b1;
    step();

    // Randomized scores and control traffic
    for (int unsigned r = 0; r < 8; r++) begin
      go_idle();
      for (int unsigned a = 0; a < DEPTH; a++)
        rom[a] = {4'($urandom_range(1, 4)), 5'($urandom_range(0, 31))};
      if (r != 7) rom[$urandom_range(0, 9)] = {4'd0, 5'($urandom)};
      tick_per = $urandom_range(4, 8);
      for (int unsigned i = 0; i < 600; i++) begin
        step();
        bus.START   = ($urandom_range(0, 15) == 0);
        bus.STOP    = ($urandom_range(0, 399) == 0);
        bus.LOOP_EN = 1'($urandom_range(0, 1));
      end
    end

    bus.START = 1'b0; bus.STOP = 1'b0;
    step();
    chk_on = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached, got no finish, want finish");
    $fatal(1, "time limit");
  end

endmodule
